// File: rtl/alu16_sequencer.sv
// alu16_sequencer: runs 16-bit ADD/ADDSP/INC/DEC as two byte passes on the shared 8-bit ALU,
// low byte first with the carry chained into the high byte, and returns the result over valid/ready.
module alu16_sequencer #(
    parameter bit FAST_IDU = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [3:0]  req_flags,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_result,
    output logic [3:0]  resp_flags,
    output logic        alu_sel,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [4:0]  alu_op,
    output logic [3:0]  alu_flag_in,
    input  logic [7:0]  alu_out,
    input  logic [3:0]  alu_flag_out
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    localparam logic [1:0] OP_ADD16 = 2'b00, OP_ADDSP = 2'b01, OP_DEC16 = 2'b11;
    localparam logic [4:0] ALU_ADD = 5'b00000, ALU_ADC = 5'b00001, ALU_SUB = 5'b00010,
                           ALU_SBC = 5'b00011, ALU_COPY = 5'b11000;
    state_t state, state_next;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [3:0]  flags;
    logic [7:0]  lo_res;
    logic        lo_c, lo_h;
    logic        fast, lo_drive, hi_drive;
    logic        unused_flags;
    assign unused_flags = &alu_flag_out[3:2];
    // INC/DEC on the internal incrementer still spend the LO slot, but leave the ALU alone
    assign fast     = FAST_IDU && op[1];
    assign lo_drive = (state == LO) && !fast;
    assign hi_drive = (state == HI);
    assign req_ready  = (state == IDLE) && !reset;
    assign resp_valid = (state == DONE);
    always_comb begin
        state_next  = state;
        alu_sel     = lo_drive || hi_drive;
        alu_op      = ALU_COPY;
        alu_a       = 8'h00;
        alu_b       = 8'h00;
        alu_flag_in = 4'h0;
        case (state)
            IDLE: state_next = req_valid ? LO : IDLE;
            LO:   state_next = fast ? DONE : HI;
            HI:   state_next = DONE;
            DONE: state_next = resp_ready ? IDLE : DONE;
        endcase
        if (lo_drive) begin
            alu_op      = (op == OP_DEC16) ? ALU_SUB : ALU_ADD;
            alu_a       = a[7:0];
            alu_b       = op[1] ? 8'h01 : b[7:0];
            alu_flag_in = flags;
        end
        if (hi_drive) begin
            alu_op      = (op == OP_DEC16) ? ALU_SBC : ALU_ADC;
            alu_a       = a[15:8];
            alu_b       = (op == OP_ADD16) ? b[15:8] : (op == OP_ADDSP) ? {8{b[7]}} : 8'h00;
            alu_flag_in = {flags[3:1], lo_c};
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op          <= 2'b00;
            a           <= 16'h0000;
            b           <= 16'h0000;
            flags       <= 4'h0;
            lo_res      <= 8'h00;
            lo_c        <= 1'b0;
            lo_h        <= 1'b0;
            resp_result <= 16'h0000;
            resp_flags  <= 4'h0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                op    <= req_op;
                a     <= req_a;
                b     <= req_b;
                flags <= req_flags;
            end
            if (lo_drive) begin
                lo_res <= alu_out;
                lo_c   <= alu_flag_out[0];
                lo_h   <= alu_flag_out[1];
            end
            if (state == LO && fast) begin
                resp_result <= (op == OP_DEC16) ? a - 16'h0001 : a + 16'h0001;
                resp_flags  <= flags;
            end
            if (hi_drive) begin
                resp_result <= {alu_out, lo_res};
                resp_flags  <= (op == OP_ADD16) ? {flags[3], 1'b0, alu_flag_out[1:0]} :
                               (op == OP_ADDSP) ? {2'b00, lo_h, lo_c} : flags;
            end
        end
    end
endmodule
